preg_checkpoint_ctrl: RTL
=========================

Name: preg_checkpoint_ctrl

Overview:
- Sequences the physical-register free list for rename, commit and branch recovery.
- Gates rename allocations against free-list empty and checkpoint-table full.
- Captures the free-list head pointer into an in-order checkpoint table, one slot per in-flight branch, tagged by branch tag.
- On a mispredict, drives a one-cycle restore into the free list, squashes younger checkpoints, and stalls rename until the free list has settled.

Parameters:
- NUM_CKPT, 4, number of in-flight branch checkpoints; must be a power of 2.
- TAG_BITS, $clog2(NUM_CKPT), branch tag width.
- PHYS_REG_BITS, 7, physical register index width; taken from the shared package.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- rename_valid  in  1  rename presents one instruction
- rename_needs_preg  in  1  instruction writes rd and needs a preg
- rename_is_branch  in  1  instruction needs a checkpoint
- rename_ready  out  1  instruction accepted this cycle when valid && ready
- rename_preg  out  PHYS_REG_BITS  allocated preg; equals fl_alloc_preg
- rename_br_tag  out  TAG_BITS  tag assigned to the branch; equals ckpt_tail index
- fl_alloc_en  out  1  free-list pop
- fl_alloc_preg  in  PHYS_REG_BITS  free-list head entry
- fl_empty  in  1  free list empty
- fl_dealloc_en  out  1  free-list push
- fl_dealloc_preg  out  PHYS_REG_BITS  preg pushed
- fl_checkpoint_en  out  1  checkpoint strobe
- fl_checkpoint_ptr  in  PHYS_REG_BITS  free-list head pointer, pre-allocation
- fl_restore_en  out  1  restore strobe
- fl_restore_ptr  out  PHYS_REG_BITS  pointer to restore
- commit_free_en  in  1  commit releases an old preg
- commit_free_preg  in  PHYS_REG_BITS  preg released
- br_resolve_valid  in  1  branch resolved
- br_resolve_tag  in  TAG_BITS  resolving branch tag
- br_mispredict  in  1  qualifies resolve as mispredict
- ckpt_full  out  1  all NUM_CKPT slots in use (debug/stall visibility)
- recovering  out  1  state != IDLE

Behaviour:
- Reset is synchronous and active-high. While rst=1: state=IDLE; ckpt_head=ckpt_tail=0 (each TAG_BITS+1 wide, MSB is the wrap bit); all slot valid/resolved bits cleared. While rst=1 every output is 0, including rename_ready and all fl_* strobes. Reset mid-recovery abandons the restore, and no fl_restore_en is issued afterwards.
- mp_now = br_resolve_valid && br_mispredict && slot[br_resolve_tag].valid.
- rename_ready = (state==IDLE) && !mp_now && !(rename_needs_preg && fl_empty) && !(rename_is_branch && ckpt_full). It is combinational.
- fire = rename_valid && rename_ready.
- fl_alloc_en = fire && rename_needs_preg.
- fl_checkpoint_en = fire && rename_is_branch.
- A checkpoint write stores saved_ptr = fl_checkpoint_ptr + (rename_needs_preg ? 1 : 0), modulo 2^PHYS_REG_BITS. This keeps a rd-writing branch's own preg. The write also sets valid=1 and resolved=0, and increments ckpt_tail at the clock edge.
- ckpt_full = (head.idx == tail.idx) && (head.wrap != tail.wrap).
- Dealloc is a pure passthrough: fl_dealloc_en=commit_free_en and fl_dealloc_preg=commit_free_preg, same cycle, in every state. Commit-side frees are always older than any branch and are never blocked.
- Correct resolve (br_resolve_valid && !br_mispredict && slot valid) sets resolved=1.
  - Each cycle, if slot[head] is valid and resolved, clear it and increment ckpt_head. At most one retire per cycle.
  - A resolve of an invalid tag is ignored.
- FSM IDLE -> RECOVER -> SETTLE -> IDLE:
  - IDLE, mp_now at cycle N:
    - latch rp = slot[tag].saved_ptr;
    - set ckpt_tail = {wrap-adjusted tag}, which squashes the tag and all younger slots (clear their valid bits);
    - go to RECOVER.
  - RECOVER (cycle N+1): fl_restore_en=1, fl_restore_ptr=rp; go to SETTLE.
  - SETTLE (cycle N+2): no strobes; go to IDLE. rename_ready can be 1 again from N+3.
  - rename_ready=0 in cycles N, N+1 and N+2.
- Mispredict while not IDLE: ignored; the branch unit guarantees the oldest mispredict is reported first. Correct resolves of surviving tags are applied in every state.
- Resolve of the head slot in the same cycle as a squash: the squash takes priority for slots at or after the tag; older slots still retire normally.

Decomposition:
- ooo_types gains: NUM_CKPT, TAG_BITS, typedef br_tag_t, typedef ckpt_entry_t {valid, resolved, saved_ptr}, typedef enum recov_state_t {IDLE, RECOVER, SETTLE}.
- Natural sub-module: ckpt_table. It is an NUM_CKPT-entry circular buffer with head/tail pointers, write-at-tail, mark-resolved, retire-at-head, truncate-tail and read-by-tag ports.
- The FSM and rename gating live in preg_checkpoint_ctrl.

Test Plan:
- Reset, then 3 rename ops with needs_preg (fl_alloc_preg 32,33,34) -> fl_alloc_en=1 each cycle, rename_preg=32,33,34; ckpt_full=0; recovering=0.
- Branch with no rd at fl_checkpoint_ptr=35 -> tag 0, saved 35. Then 5 allocs. Then mispredict tag 0 -> rename_ready=0 for 3 cycles; fl_restore_en=1 with ptr 35 exactly at N+1; next alloc sees p35.
- JAL (needs_preg, is_branch) at ptr 40 -> fl_alloc_en=1 and fl_checkpoint_en=1 same cycle, saved=41. Mispredict -> restore ptr 41.
- Branches tags 0,1,2, then mispredict tag 1 -> tag 0 still valid; next branch receives tag 1; tag 2 is never restored.
- 4 unresolved branches -> ckpt_full=1; a 5th branch is stalled while a non-branch alloc still fires. Resolve tag 0 correct -> head advances next cycle, ckpt_full=0, 5th branch gets tag 0.
- fl_empty=1: needs_preg op stalled with fl_alloc_en=0; non-preg op accepted; commit_free_en passes through in the same cycle, including in RECOVER. rst asserted in RECOVER -> all outputs 0, and no restore after rst deasserts.

Source files
------------

// File: rtl/ooo_types_pkg.sv
// Shared out-of-order core types: physical register indices, branch checkpoints
// and the recovery state machine encoding.
package ooo_types;
    localparam int PHYS_REG_BITS = 7;
    localparam int NUM_CKPT      = 4;
    localparam int TAG_BITS      = $clog2(NUM_CKPT);

    typedef logic [PHYS_REG_BITS-1:0] preg_t;
    typedef logic [TAG_BITS-1:0]      br_tag_t;

    typedef struct packed {
        logic  valid;
        logic  resolved;
        preg_t saved_ptr;
    } ckpt_entry_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RECOVER = 2'd1,
        SETTLE  = 2'd2
    } recov_state_t;
endpackage

// File: rtl/preg_checkpoint_ctrl_ckpt_table.sv
// In-order branch checkpoint buffer: write at tail, mark resolved by tag,
// retire resolved entries from head, truncate tail on a squash.
module ckpt_table
    import ooo_types::*;
#(
    parameter int NUM_CKPT = ooo_types::NUM_CKPT,
    parameter int TAG_BITS = $clog2(NUM_CKPT)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                wr_en,
    input  preg_t               wr_ptr,
    output logic [TAG_BITS-1:0] tail_tag,
    input  logic                resolve_en,
    input  logic [TAG_BITS-1:0] resolve_tag,
    input  logic                trunc_en,
    input  logic [TAG_BITS-1:0] trunc_tag,
    input  logic [TAG_BITS-1:0] rd_tag,
    output logic                rd_valid,
    output preg_t               rd_ptr,
    output logic                full
);
    typedef logic [TAG_BITS:0] ptr_t;

    ptr_t                        head, tail, trunc_tail;
    ckpt_entry_t [NUM_CKPT-1:0]  slot;
    logic [TAG_BITS-1:0]         head_idx, tail_idx, trunc_off;
    logic [NUM_CKPT-1:0]         kill;
    logic                        retire;

    // Age of a slot relative to the oldest live checkpoint.
    function automatic logic [TAG_BITS-1:0] age(input logic [TAG_BITS-1:0] idx,
                                                input logic [TAG_BITS-1:0] base);
        return idx - base;
    endfunction

    assign head_idx = head[TAG_BITS-1:0];
    assign tail_idx = tail[TAG_BITS-1:0];
    assign tail_tag = tail_idx;
    assign full     = (head_idx == tail_idx) && (head[TAG_BITS] != tail[TAG_BITS]);
    assign rd_valid = slot[rd_tag].valid;
    assign rd_ptr   = slot[rd_tag].saved_ptr;

    // A tag below the head index has wrapped past it, so it carries the other lap bit.
    assign trunc_tail = {(trunc_tag >= head_idx) ? head[TAG_BITS] : ~head[TAG_BITS], trunc_tag};

    always_comb begin
        kill      = '0;
        trunc_off = age(trunc_tag, head_idx);
        for (int i = 0; i < NUM_CKPT; i++) begin
            if (trunc_en && (age(TAG_BITS'(i), head_idx) >= trunc_off))
                kill[i] = 1'b1;
        end
        retire = slot[head_idx].valid && slot[head_idx].resolved && !kill[head_idx];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head <= '0;
            tail <= '0;
            slot <= '0;
        end else begin
            for (int i = 0; i < NUM_CKPT; i++) begin
                if (kill[i]) begin
                    slot[i].valid    <= 1'b0;
                    slot[i].resolved <= 1'b0;
                end else if (resolve_en && (resolve_tag == TAG_BITS'(i)) && slot[i].valid) begin
                    slot[i].resolved <= 1'b1;
                end
            end
            if (retire) begin
                slot[head_idx].valid    <= 1'b0;
                slot[head_idx].resolved <= 1'b0;
                head                    <= head + 1'b1;
            end
            if (wr_en) begin
                slot[tail_idx] <= '{valid: 1'b1, resolved: 1'b0, saved_ptr: wr_ptr};
                tail           <= tail + 1'b1;
            end else if (trunc_en) begin
                tail <= trunc_tail;
            end
        end
    end
endmodule

// File: rtl/preg_checkpoint_ctrl.sv
// Rename-side physical register free-list sequencer: allocation gating,
// branch checkpointing and the restore/settle recovery sequence.
module preg_checkpoint_ctrl
    import ooo_types::*;
#(
    parameter int NUM_CKPT = ooo_types::NUM_CKPT,
    parameter int TAG_BITS = $clog2(NUM_CKPT)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                rename_valid,
    input  logic                rename_needs_preg,
    input  logic                rename_is_branch,
    output logic                rename_ready,
    output preg_t               rename_preg,
    output logic [TAG_BITS-1:0] rename_br_tag,
    output logic                fl_alloc_en,
    input  preg_t               fl_alloc_preg,
    input  logic                fl_empty,
    output logic                fl_dealloc_en,
    output preg_t               fl_dealloc_preg,
    output logic                fl_checkpoint_en,
    input  preg_t               fl_checkpoint_ptr,
    output logic                fl_restore_en,
    output preg_t               fl_restore_ptr,
    input  logic                commit_free_en,
    input  preg_t               commit_free_preg,
    input  logic                br_resolve_valid,
    input  logic [TAG_BITS-1:0] br_resolve_tag,
    input  logic                br_mispredict,
    output logic                ckpt_full,
    output logic                recovering
);
    recov_state_t        state, state_nxt;
    preg_t               rp, rd_ptr;
    logic [TAG_BITS-1:0] tail_tag;
    logic                tbl_full, rd_valid;
    logic                mp_now, start_recov, fire;

    assign mp_now      = br_resolve_valid && br_mispredict && rd_valid;
    assign start_recov = (state == IDLE) && mp_now && !rst;

    assign rename_ready = !rst && (state == IDLE) && !mp_now
                          && !(rename_needs_preg && fl_empty)
                          && !(rename_is_branch && tbl_full);
    assign fire             = rename_valid && rename_ready;
    assign fl_alloc_en      = fire && rename_needs_preg;
    assign fl_checkpoint_en = fire && rename_is_branch;

    assign rename_preg   = rst ? '0 : fl_alloc_preg;
    assign rename_br_tag = rst ? '0 : tail_tag;
    assign ckpt_full     = !rst && tbl_full;
    assign recovering    = !rst && (state != IDLE);

    // Commit frees are older than every in-flight branch, so they bypass recovery.
    assign fl_dealloc_en   = !rst && commit_free_en;
    assign fl_dealloc_preg = rst ? '0 : commit_free_preg;

    assign fl_restore_en  = !rst && (state == RECOVER);
    assign fl_restore_ptr = fl_restore_en ? rp : '0;

    // A rd-writing branch pops its own preg this cycle; the saved head skips past it.
    ckpt_table #(
        .NUM_CKPT (NUM_CKPT),
        .TAG_BITS (TAG_BITS)
    ) u_tbl (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (fl_checkpoint_en),
        .wr_ptr      (fl_checkpoint_ptr + preg_t'(rename_needs_preg)),
        .tail_tag    (tail_tag),
        .resolve_en  (br_resolve_valid && !br_mispredict),
        .resolve_tag (br_resolve_tag),
        .trunc_en    (start_recov),
        .trunc_tag   (br_resolve_tag),
        .rd_tag      (br_resolve_tag),
        .rd_valid    (rd_valid),
        .rd_ptr      (rd_ptr),
        .full        (tbl_full)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mp_now) state_nxt = RECOVER;
            RECOVER: state_nxt = SETTLE;
            SETTLE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rp    <= '0;
        end else begin
            state <= state_nxt;
            if (start_recov) rp <= rd_ptr;
        end
    end
endmodule
